// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the shot-clock countdown timer.
//   state_t    : controller states (IDLE, RUNNING, PAUSED, EXPIRED)
//   MAX_COUNT  : largest value the two-digit display path may ever see
//   sat_count  : clamps a 5-bit request to MAX_COUNT
// -----------------------------------------------------------------------------
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [4:0] MAX_COUNT = 5'd30;

  // min(value, 30): a 5-bit load request can encode 31, which the display
  // cannot show, so it is pulled back to the maximum.
  function automatic logic [4:0] sat_count(input logic [4:0] value);
    return (value > MAX_COUNT) ? MAX_COUNT : value;
  endfunction

endpackage

// File: rtl/countdown_timer_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Per-second divider for the countdown timer. Counts enabled clk cycles
// 0..TICKS_PER_SEC-1 and flags the terminal cycle.
//   clk    in  : system clock, rising edge
//   reset  in  : asynchronous active-high reset, count -> 0
//   enable in  : advance the count this cycle
//   clr    in  : synchronous return to 0 (wins over enable)
//   tick   out : combinational, high while enabled at the terminal count;
//                the parent registers the resulting decrement/tick
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam int         W         = $clog2(TICKS_PER_SEC);
  localparam logic [W-1:0] LAST    = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);

  // When disabled at the terminal count the value simply holds, so a pause
  // on the terminal cycle resumes straight into the decrement.
  assign tick = enable & w_at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_at_last ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Shot-clock style seconds countdown feeding a two-digit seven-segment
// decoder. Holds 0..30, decrements once per second while running and flags
// expiry at 0. Controls are level inputs acted on at their rising edge.
//   clk        in  : system clock, rising edge
//   reset      in  : asynchronous active-high reset
//   start      in  : rising edge starts/resumes (IDLE or PAUSED, number > 0)
//   pause      in  : rising edge pauses a running count
//   clear      in  : rising edge -> IDLE, number = START_VALUE
//   load       in  : rising edge loads min(load_value,30) unless RUNNING
//   load_value in  : 5-bit value for load
//   number     out : current count, 0..30
//   running    out : high in RUNNING
//   expired    out : high in EXPIRED
//   tick       out : one-cycle pulse on each decrement
// Per-cycle priority: clear > load > pause > start.
// -----------------------------------------------------------------------------
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int         TICKS_PER_SEC = 50000000,
  parameter logic [4:0] START_VALUE   = 5'd30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] load_value,
  output logic [4:0] number,
  output logic       running,
  output logic       expired,
  output logic       tick
);

  state_t     r_state;
  logic [4:0] r_number;
  logic       r_running;
  logic       r_expired;
  logic       r_tick;

  // Previous-cycle copies of the controls for rising-edge detection.
  logic r_start_prev;
  logic r_pause_prev;
  logic r_clear_prev;
  logic r_load_prev;

  logic w_start_edge;
  logic w_pause_edge;
  logic w_clear_edge;
  logic w_load_edge;

  state_t     w_state_next;
  logic [4:0] w_number_next;
  logic       w_dec;
  logic       w_presc_en;
  logic       w_presc_clr;
  logic       w_term;
  logic       w_running_next;
  logic       w_expired_next;
  logic       w_tick_next;

  assign w_start_edge = start & ~r_start_prev;
  assign w_pause_edge = pause & ~r_pause_prev;
  assign w_clear_edge = clear & ~r_clear_prev;
  assign w_load_edge  = load  & ~r_load_prev;

  // The prescaler only advances on a running cycle that is not being
  // interrupted by clear or pause; a load edge is ignored while running.
  // Kept apart from the next-state logic so the terminal flag coming back
  // from the prescaler has no path into its own enable.
  assign w_presc_en  = (r_state == ST_RUNNING) & ~w_clear_edge & ~w_pause_edge;
  assign w_presc_clr = w_clear_edge | (w_load_edge & (r_state != ST_RUNNING));

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (w_presc_en),
    .clr    (w_presc_clr),
    .tick   (w_term)
  );

  // State register (also holds the count, edge history and outputs).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_number     <= START_VALUE;
      r_running    <= 1'b0;
      r_expired    <= 1'b0;
      r_tick       <= 1'b0;
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
      r_clear_prev <= 1'b0;
      r_load_prev  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_number     <= w_number_next;
      r_running    <= w_running_next;
      r_expired    <= w_expired_next;
      r_tick       <= w_tick_next;
      r_start_prev <= start;
      r_pause_prev <= pause;
      r_clear_prev <= clear;
      r_load_prev  <= load;
    end
  end

  // Next-state and next-count logic.
  always_comb begin
    w_state_next  = r_state;
    w_number_next = r_number;
    w_dec         = 1'b0;
    if (w_clear_edge) begin
      w_state_next  = ST_IDLE;
      w_number_next = START_VALUE;
    end else if (w_load_edge && (r_state != ST_RUNNING)) begin
      w_state_next  = ST_IDLE;
      w_number_next = sat_count(load_value);
    end else if (w_pause_edge) begin
      // A pause edge also masks a coincident start edge, even when there is
      // nothing running to pause.
      if (r_state == ST_RUNNING) begin
        w_state_next = ST_PAUSED;
      end
    end else if (w_start_edge && ((r_state == ST_IDLE) || (r_state == ST_PAUSED))
                 && (r_number != 5'd0)) begin
      w_state_next = ST_RUNNING;
    end else if ((r_state == ST_RUNNING) && w_term) begin
      w_dec         = 1'b1;
      w_number_next = r_number - 5'd1;
      if (r_number == 5'd1) begin
        w_state_next = ST_EXPIRED;
      end
    end
  end

  // Output logic: decoded from the next state so every output is registered.
  always_comb begin
    w_running_next = (w_state_next == ST_RUNNING);
    w_expired_next = (w_state_next == ST_EXPIRED);
    w_tick_next    = w_dec;
  end

  assign number  = r_number;
  assign running = r_running;
  assign expired = r_expired;
  assign tick    = r_tick;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int         TPS   = 4;
  localparam logic [4:0] START = 5'd30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_value = 5'd0;
  logic [4:0] number;
  logic       running;
  logic       expired;
  logic       tick;

  logic async_chk = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0] num;
    logic       run;
    logic       exp;
    logic       tk;
  } exp_t;

  exp_t q[$];

  countdown_timer #(
    .TICKS_PER_SEC(TPS),
    .START_VALUE  (START)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .number     (number),
    .running    (running),
    .expired    (expired),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Behavioural view: a mode, the seconds left, and how many running cycles
  // of the current second have elapsed.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int   m_mode = M_IDLE;
  int   m_secs = 30;
  int   m_elapsed = 0;
  logic m_ps = 0, m_pp = 0, m_pc = 0, m_pl = 0;

  task automatic model_reset(output exp_t e);
    m_mode = M_IDLE; m_secs = int'(START); m_elapsed = 0;
    m_ps = 0; m_pp = 0; m_pc = 0; m_pl = 0;
    e.num = START; e.run = 0; e.exp = 0; e.tk = 0;
  endtask

  task automatic model_step(input logic rst, input logic s, input logic p,
                            input logic c, input logic l, input logic [4:0] lv,
                            output exp_t e);
    logic es, ep, ec, el, tk;
    if (rst) begin
      model_reset(e);
      return;
    end
    es = s & ~m_ps; ep = p & ~m_pp; ec = c & ~m_pc; el = l & ~m_pl;
    m_ps = s; m_pp = p; m_pc = c; m_pl = l;
    tk = 0;
    if (ec) begin
      m_mode = M_IDLE; m_secs = int'(START); m_elapsed = 0;
    end else if (el && m_mode != M_RUN) begin
      m_mode = M_IDLE; m_secs = (int'(lv) > 30) ? 30 : int'(lv); m_elapsed = 0;
    end else if (ep) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
    end else if (es && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs > 0) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == TPS) begin
        m_elapsed = 0;
        tk = 1;
        m_secs = m_secs - 1;
        if (m_secs == 0) m_mode = M_EXP;
      end
    end
    e.num = 5'(m_secs);
    e.run = (m_mode == M_RUN);
    e.exp = (m_mode == M_EXP);
    e.tk  = tk;
  endtask

  // ---------------- stimulus ----------------
  // Drive one cycle's inputs at the falling edge and queue what the DUT
  // must show after the following rising edge.
  task automatic step(input logic rst, input logic s, input logic p,
                      input logic c, input logic l, input logic [4:0] lv);
    exp_t e;
    @(negedge clk);
    reset = rst; start = s; pause = p; clear = c; load = l; load_value = lv;
    model_step(rst, s, p, c, l, lv, e);
    q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, load_value);
  endtask

  task automatic pulse(input logic s, input logic p, input logic c,
                       input logic l, input logic [4:0] lv);
    step(0, s, p, c, l, lv);
    step(0, 0, 0, 0, 0, lv);
  endtask

  // Direct comparison of the current outputs against an explicit expectation.
  task automatic check_now(input string tag, input logic [4:0] en, input logic er,
                           input logic ee, input logic et);
    n_checks++;
    if (number !== en || running !== er || expired !== ee || tick !== et) begin
      n_fail++;
      $display("FAIL %s t=%0t: got number=%0d running=%b expired=%b tick=%b, want number=%0d running=%b expired=%b tick=%b",
               tag, $time, number, running, expired, tick, en, er, ee, et);
    end else begin
      $display("chk %0d %s t=%0t number=%0d running=%b expired=%b tick=%b ok",
               n_checks, tag, $time, number, running, expired, tick);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge async_chk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (number !== e.num || running !== e.run || expired !== e.exp || tick !== e.tk) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got number=%0d running=%b expired=%b tick=%b, want number=%0d running=%b expired=%b tick=%b",
                   $time, number, running, expired, tick, e.num, e.run, e.exp, e.tk);
        end else begin
          $display("chk %0d t=%0t number=%0d running=%b expired=%b tick=%b ok",
                   n_checks, $time, number, running, expired, tick);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    exp_t e;
    logic s, p, c, l;

    // Reset held for a few cycles, then released.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    idle_cycles(2);
    check_now("reset_state", START, 1'b0, 1'b0, 1'b0);

    // Full countdown from 30 to expiry (120 running cycles) plus margin.
    pulse(1, 0, 0, 0, 0);
    idle_cycles(124);
    check_now("expired_wait", 5'd0, 1'b0, 1'b1, 1'b0);

    // Start while expired does nothing; clear returns to IDLE at 30.
    pulse(1, 0, 0, 0, 0);
    idle_cycles(2);
    pulse(0, 0, 1, 0, 0);
    idle_cycles(2);

    // Load 3 and run to expiry.
    pulse(0, 0, 0, 1, 5'd3);
    pulse(1, 0, 0, 0, 0);
    idle_cycles(16);

    // Load 10, run two prescaler cycles, pause for 20, resume.
    pulse(0, 0, 0, 1, 5'd10);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    idle_cycles(20);
    pulse(1, 0, 0, 0, 0);
    idle_cycles(6);

    // Pause landing on the terminal-count cycle, then resume.
    pulse(0, 0, 0, 1, 5'd5);
    step(0, 1, 0, 0, 0, 0);
    idle_cycles(3);
    pulse(0, 1, 0, 0, 0);
    idle_cycles(4);
    pulse(1, 0, 0, 0, 0);
    idle_cycles(3);

    // Clear on a terminal-count cycle.
    step(0, 0, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(1, 0, 0, 0, 0);
    idle_cycles(3);
    pulse(0, 0, 1, 0, 0);
    idle_cycles(1);

    // Load of 31 saturates; load while running is ignored.
    pulse(0, 0, 0, 1, 5'd31);
    pulse(1, 0, 0, 0, 0);
    idle_cycles(3);
    pulse(0, 0, 0, 1, 5'd5);
    idle_cycles(10);

    // Start and pause together from IDLE: stays IDLE.
    pulse(0, 0, 1, 0, 0);
    pulse(1, 1, 0, 0, 0);
    idle_cycles(3);

    // Start with number 0 in IDLE is ignored.
    pulse(0, 0, 0, 1, 5'd0);
    pulse(1, 0, 0, 0, 0);
    idle_cycles(2);

    // Control held high through reset release counts as an edge.
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle_cycles(5);

    // Asynchronous reset mid-count at number=17, prescaler=2.
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 0, 1, 5'd17);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    model_reset(e);
    q.push_back(e);
    reset = 1'b1;
    async_chk = 1'b1;
    #1;
    async_chk = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    idle_cycles(3);

    // Randomised control levels.
    s = 0; p = 0; c = 0; l = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)  s = ~s;
      if ($urandom_range(0, 9) == 0)  p = ~p;
      if ($urandom_range(0, 39) == 0) c = ~c;
      if ($urandom_range(0, 11) == 0) l = ~l;
      step(($urandom_range(0, 399) == 0), s, p, c, l, 5'($urandom_range(0, 31)));
    end
    idle_cycles(2);

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
